// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: shared widths, constants and types for the sigmoid activation blocks
package sigmoid_pkg;
  localparam int GW = 24;
  localparam int YW = 8;
  localparam int FRAC = 14;
  localparam int DW = 14;
  localparam int PW = GW + DW;
  localparam int SIG_ONE = 128;
  typedef logic signed [GW-1:0] grad_t;
  typedef logic [YW-1:0] act_t;
  typedef logic [DW-1:0] deriv_t;
  typedef logic signed [PW-1:0] prod_t;
endpackage

// File: rtl/sigmoid_deriv.sv
// sigmoid_deriv: clamps y to one and forms the unsigned derivative term y*(128-y)
module sigmoid_deriv
  import sigmoid_pkg::*;
(
  input  act_t   y_i,
  output deriv_t d_o
);
  act_t yc;
  // Clamp y to 128, then multiply in 14 bits (peak 4096 at y=64)
  always_comb begin
    yc = (y_i > act_t'(SIG_ONE)) ? act_t'(SIG_ONE) : y_i;
    d_o = deriv_t'(yc) * deriv_t'(act_t'(SIG_ONE) - yc);
  end
endmodule

// File: rtl/sigmoid_backward.sv
// sigmoid_backward: 3-stage streaming g*y*(128-y)/2^14 with valid/ready backpressure
module sigmoid_backward
  import sigmoid_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  act_t  in_y,
  input  grad_t in_grad,
  input  logic  in_last,
  output logic  out_valid,
  input  logic  out_ready,
  output grad_t out_grad,
  output logic  out_last,
  output logic  busy
);
  localparam prod_t RND = prod_t'(1) <<< (FRAC - 1);
  logic   v1_q, v2_q, v3_q, l1_q, l2_q, l3_q;
  logic   rdy1, rdy2, rdy3;
  deriv_t d_d, d1_q;
  grad_t  g1_q, r_d, r3_q;
  prod_t  p_d, p2_q;
  sigmoid_deriv u_deriv (
    .y_i(in_y),
    .d_o(d_d)
  );
  // Stage readiness ripples back from the output so bubbles collapse under stall
  always_comb begin
    rdy3 = !v3_q || out_ready;
    rdy2 = !v2_q || rdy3;
    rdy1 = !v1_q || rdy2;
    p_d = prod_t'(g1_q) * prod_t'(d1_q);
    r_d = grad_t'((p2_q + RND) >>> FRAC);
  end
  // S1: capture clamped derivative term, gradient and sideband
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
      g1_q <= '0;
      l1_q <= 1'b0;
    end else if (rdy1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        d1_q <= d_d;
        g1_q <= in_grad;
        l1_q <= in_last;
      end
    end
  // S2: full-precision signed product
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2_q <= 1'b0;
      p2_q <= '0;
      l2_q <= 1'b0;
    end else if (rdy2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        p2_q <= p_d;
        l2_q <= l1_q;
      end
    end
  // S3: round half up and rescale; result magnitude fits GW so truncation is exact
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v3_q <= 1'b0;
      r3_q <= '0;
      l3_q <= 1'b0;
    end else if (rdy3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        r3_q <= r_d;
        l3_q <= l2_q;
      end
    end
  assign in_ready = rdy1;
  assign out_valid = v3_q;
  assign out_grad = r3_q;
  assign out_last = l3_q;
  assign busy = v1_q | v2_q | v3_q;
endmodule
